// File: rtl/lzd_normalizer_pkg.sv
// Shared FPU normalizer package: FSM encoding and default widths.
package lzd_normalizer_pkg;
  localparam int SWR_DEF = 26;
  localparam int EWR_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } norm_state_t;
endpackage

// File: rtl/lzd_normalizer_norm_shift_reg.sv
// Significand register: parallel load or shift-left-by-one, async active-low clear.
module norm_shift_reg #(
  parameter int SWR = 26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           shift,
  input  logic [SWR-1:0] d,
  output logic [SWR-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= {q[SWR-2:0], 1'b0};
  end
endmodule

// File: rtl/lzd_normalizer.sv
// Sequential leading-zero normalizer: one left shift per cycle until the hidden bit is set,
// or a single right shift on adder carry-out. Reports the applied left-shift count.
module lzd_normalizer
  import lzd_normalizer_pkg::*;
#(
  parameter int SWR = SWR_DEF,
  parameter int EWR = EWR_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [SWR-1:0] Op_i,
  input  logic           C_i,
  output logic           busy_o,
  output logic           ready_o,
  output logic [SWR-1:0] Norm_o,
  output logic [EWR-1:0] Shift_o,
  output logic           Ovf_o,
  output logic           Zero_o
);
  norm_state_t    state, state_n;
  logic           load, shift;
  logic [SWR-1:0] load_val;
  logic           op_zero;

  assign op_zero = (Op_i == '0);

  norm_shift_reg #(.SWR(SWR)) u_sreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (load_val),
    .q     (Norm_o)
  );

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    shift    = 1'b0;
    load_val = Op_i;
    case (state)
      IDLE: if (start_i) begin
        load = 1'b1;
        // Carry wins over every other case; a zero Op loads zero naturally.
        if (C_i) load_val = {1'b1, Op_i[SWR-1:1]};
        state_n = (C_i || op_zero || Op_i[SWR-1]) ? DONE : SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (Norm_o[SWR-2]) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // busy/ready are flopped from the next state so every output is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      ready_o <= 1'b0;
      Shift_o <= '0;
      Ovf_o   <= 1'b0;
      Zero_o  <= 1'b0;
    end else begin
      state   <= state_n;
      busy_o  <= (state_n != IDLE);
      ready_o <= (state_n == DONE);
      if (load) begin
        Shift_o <= '0;
        Ovf_o   <= C_i;
        Zero_o  <= !C_i && op_zero;
      end else if (shift) begin
        Shift_o <= Shift_o + 1'b1;
      end
    end
  end
endmodule
